// File: rtl/text_buffer_ram_if.sv
// Bundle between game control / text renderer and the character buffer.
// Latency: none (wires only).
// Backpressure: the single-cell write uses valid/ready. Read, fill and status signals have no flow control.
//
// Signals
//   char_x, char_y   : renderer read coordinates
//   char_code        : registered read data
//   wr_valid/ready   : cell write handshake
//   wr_x, wr_y       : write coordinates
//   wr_char          : write data
//   fill_start       : bulk fill request
//   fill_char        : bulk fill value
//   busy             : a sweep is in progress
//   done             : one-cycle pulse at the end of a sweep
interface text_buffer_ram_if #(
    parameter int SIZE_X = 16,
    parameter int SIZE_Y = 4,
    parameter int CHAR_W = 7
);
    localparam int XW = $clog2(SIZE_X);
    localparam int YW = $clog2(SIZE_Y);

    logic [XW-1:0]     char_x;
    logic [YW-1:0]     char_y;
    logic [CHAR_W-1:0] char_code;
    logic              wr_valid;
    logic              wr_ready;
    logic [XW-1:0]     wr_x;
    logic [YW-1:0]     wr_y;
    logic [CHAR_W-1:0] wr_char;
    logic              fill_start;
    logic [CHAR_W-1:0] fill_char;
    logic              busy;
    logic              done;

    // The buffer itself.
    modport slave (
        input  char_x, char_y, wr_valid, wr_x, wr_y, wr_char, fill_start, fill_char,
        output char_code, wr_ready, busy, done
    );

    // Game control / renderer side.
    modport master (
        output char_x, char_y, wr_valid, wr_x, wr_y, wr_char, fill_start, fill_char,
        input  char_code, wr_ready, busy, done
    );
endinterface

// File: rtl/text_buffer_ram.sv
// Writable SIZE_X x SIZE_Y character buffer with a reset-time init sweep and a bulk fill engine.
// Latency: 1 cycle from char_x/char_y to char_code. A sweep takes SIZE_X*SIZE_Y cycles.
// Backpressure: wr_ready is low during sweeps and while fill_start is high. A held write is taken once idle.
//
// Ports
//   clk, rst : clock and synchronous active-high reset
//   bus      : text_buffer_ram_if slave modport (read port, write handshake, fill control, status)
module text_buffer_ram #(
    parameter int SIZE_X = 16,
    parameter int SIZE_Y = 4,
    parameter int CHAR_W = 7,
    parameter logic [8*SIZE_X*SIZE_Y-1:0] INIT_DATA = {(SIZE_X*SIZE_Y){8'h20}}
) (
    input  logic             clk,
    input  logic             rst,
    text_buffer_ram_if.slave bus
);
    localparam int N     = SIZE_X * SIZE_Y;
    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [CHAR_W-1:0] fill_char_q;
    logic [CHAR_W-1:0] char_code_q;
    logic              busy_q;
    logic              done_q;

    // No reset on the storage array; INIT rewrites every cell after reset.
    logic [CHAR_W-1:0] mem [N];

    logic              rd_in_range;
    logic              wr_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_rdy;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_addr;
    logic [CHAR_W-1:0] mem_wdat;

    // Address decode. The index is only meaningful when the coordinates are in range.
    assign rd_in_range = (int'(bus.char_x) < SIZE_X) && (int'(bus.char_y) < SIZE_Y);
    assign wr_in_range = (int'(bus.wr_x) < SIZE_X) && (int'(bus.wr_y) < SIZE_Y);
    assign rd_idx      = IDX_W'(int'(bus.char_y) * SIZE_X + int'(bus.char_x));
    assign wr_idx      = IDX_W'(int'(bus.wr_y) * SIZE_X + int'(bus.wr_x));

    // A fill request wins over a same-cycle write. The write master holds its request.
    assign wr_rdy = (state_q == ST_IDLE) && !bus.fill_start && !rst;

    // Single write port shared by the init sweep, the fill sweep and the cell write.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cnt_q;
        mem_wdat = fill_char_q;
        case (state_q)
            ST_INIT: begin
                mem_we   = 1'b1;
                // The first character of INIT_DATA sits in the top byte.
                mem_wdat = INIT_DATA[8*(N-1-int'(cnt_q)) +: CHAR_W];
            end
            ST_FILL: begin
                mem_we = 1'b1;
            end
            ST_IDLE: begin
                // Out-of-range writes complete the handshake but are dropped here.
                mem_we   = bus.wr_valid && wr_rdy && wr_in_range;
                mem_addr = wr_idx;
                mem_wdat = bus.wr_char;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
    end

    // Read-first: a same-cycle write shows up on the following read.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_code_q <= '0;
        end else begin
            char_code_q <= rd_in_range ? mem[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            fill_char_q <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_INIT, ST_FILL: begin
                    if (cnt_q == LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.fill_start) begin
                        state_q     <= ST_FILL;
                        fill_char_q <= bus.fill_char;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.char_code = char_code_q;
    assign bus.wr_ready  = wr_rdy;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_text_buffer_ram.sv
// Directed bench for text_buffer_ram with a 5x3 grid initialised to "ABCDEFGHIJKLMNO".
// Inputs are driven 1 ns after the rising edge and outputs are sampled away from it.
// Handshakes are counted on the falling edge, where the inputs and wr_ready are stable.
module tb_text_buffer_ram;
    localparam int SX = 5;
    localparam int SY = 3;
    localparam int CW = 7;
    localparam int N  = SX * SY;
    localparam logic [8*N-1:0] INIT_STR = "ABCDEFGHIJKLMNO";

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_buffer_ram_if #(.SIZE_X(SX), .SIZE_Y(SY), .CHAR_W(CW)) ifc ();

    text_buffer_ram #(
        .SIZE_X   (SX),
        .SIZE_Y   (SY),
        .CHAR_W   (CW),
        .INIT_DATA(INIT_STR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hs_cnt   = 0;
    logic [CW-1:0] exp_mem [N];

    always @(negedge clk) begin
        if (ifc.wr_valid === 1'b1 && ifc.wr_ready === 1'b1) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cell(input int x, input int y, output logic [CW-1:0] d);
        ifc.char_x = 3'(x);
        ifc.char_y = 2'(y);
        step();
        d = ifc.char_code;
    endtask

    task automatic check_all(input string tag);
        logic [CW-1:0] d;
        for (int i = 0; i < N; i++) begin
            read_cell(i % SX, i / SX, d);
            check($sformatf("%s cell %0d", tag, i), 32'(d), 32'(exp_mem[i]));
        end
    endtask

    // Counts busy cycles from now until busy falls, then expects the done pulse.
    task automatic wait_sweep(input string tag, input int exp_busy);
        int nb;
        int nd;
        nb = 0;
        nd = 0;
        while (ifc.busy === 1'b1 && nb < 100) begin
            if (ifc.done === 1'b1) nd++;
            nb++;
            step();
        end
        check({tag, " busy cycles"}, 32'(nb), 32'(exp_busy));
        check({tag, " done during sweep"}, 32'(nd), 32'd0);
        check({tag, " done pulse"}, 32'(ifc.done), 32'd1);
    endtask

    task automatic set_init_model();
        for (int i = 0; i < N; i++) exp_mem[i] = CW'(8'h41 + i);
    endtask

    task automatic set_fill_model(input logic [CW-1:0] c);
        for (int i = 0; i < N; i++) exp_mem[i] = c;
    endtask

    initial begin
        logic [CW-1:0] d;
        int hs0;
        int nb;

        ifc.char_x     = '0;
        ifc.char_y     = '0;
        ifc.wr_valid   = 1'b0;
        ifc.wr_x       = '0;
        ifc.wr_y       = '0;
        ifc.wr_char    = '0;
        ifc.fill_start = 1'b0;
        ifc.fill_char  = '0;

        // Reset state
        step();
        step();
        check("rst char_code", 32'(ifc.char_code), 32'h0);
        check("rst busy", 32'(ifc.busy), 32'd1);
        check("rst done", 32'(ifc.done), 32'd0);
        check("rst wr_ready", 32'(ifc.wr_ready), 32'd0);

        // Init sweep
        rst = 1'b0;
        wait_sweep("init", 15);
        step();
        check("init done once", 32'(ifc.done), 32'd0);
        check("init idle busy", 32'(ifc.busy), 32'd0);
        set_init_model();
        read_cell(2, 1, d);
        check("read (2,1)", 32'(d), 32'h48);
        read_cell(4, 2, d);
        check("read (4,2)", 32'(d), 32'h4F);
        check_all("init");

        // Held write with same-cycle read of the target cell
        hs0 = hs_cnt;
        ifc.char_x   = 3'd3;
        ifc.char_y   = 2'd0;
        ifc.wr_x     = 3'd3;
        ifc.wr_y     = 2'd0;
        ifc.wr_char  = 7'h5A;
        ifc.wr_valid = 1'b1;
        #1;
        check("wr_ready idle", 32'(ifc.wr_ready), 32'd1);
        step();
        check("read-first old", 32'(ifc.char_code), 32'h44);
        check("wr_ready 2nd", 32'(ifc.wr_ready), 32'd1);
        step();
        check("read new", 32'(ifc.char_code), 32'h5A);
        ifc.wr_valid = 1'b0;
        check("write handshakes", 32'(hs_cnt - hs0), 32'd2);
        exp_mem[3] = 7'h5A;

        // Fill with a colliding write held through the sweep
        hs0 = hs_cnt;
        ifc.fill_start = 1'b1;
        ifc.fill_char  = 7'h20;
        ifc.wr_x       = 3'd1;
        ifc.wr_y       = 2'd0;
        ifc.wr_char    = 7'h31;
        ifc.wr_valid   = 1'b1;
        #1;
        check("wr_ready vs fill", 32'(ifc.wr_ready), 32'd0);
        step();
        ifc.fill_start = 1'b0;
        ifc.fill_char  = 7'h55;
        #1;
        check("wr_ready in fill", 32'(ifc.wr_ready), 32'd0);
        check("fill busy", 32'(ifc.busy), 32'd1);
        wait_sweep("fill", 15);
        check("wr_ready after fill", 32'(ifc.wr_ready), 32'd1);
        step();
        ifc.wr_valid = 1'b0;
        check("fill done once", 32'(ifc.done), 32'd0);
        check("pending handshake", 32'(hs_cnt - hs0), 32'd1);
        set_fill_model(7'h20);
        exp_mem[1] = 7'h31;
        check_all("fill");

        // Out-of-range writes are accepted and dropped
        for (int k = 0; k < 2; k++) begin
            hs0 = hs_cnt;
            ifc.wr_x     = (k == 0) ? 3'd6 : 3'd0;
            ifc.wr_y     = (k == 0) ? 2'd1 : 2'd3;
            ifc.wr_char  = 7'h41;
            ifc.wr_valid = 1'b1;
            #1;
            check($sformatf("oor%0d wr_ready", k), 32'(ifc.wr_ready), 32'd1);
            step();
            ifc.wr_valid = 1'b0;
            check($sformatf("oor%0d handshake", k), 32'(hs_cnt - hs0), 32'd1);
        end
        check_all("oor");
        read_cell(5, 0, d);
        check("read x=5", 32'(d), 32'h0);
        read_cell(0, 3, d);
        check("read y=3", 32'(d), 32'h0);

        // Reset in the middle of a fill
        ifc.fill_start = 1'b1;
        ifc.fill_char  = 7'h2A;
        step();
        ifc.fill_start = 1'b0;
        ifc.char_x     = 3'd0;
        ifc.char_y     = 2'd0;
        repeat (6) step();
        check("read during fill", 32'(ifc.char_code), 32'h2A);
        rst = 1'b1;
        step();
        check("mid-fill rst char_code", 32'(ifc.char_code), 32'h0);
        check("mid-fill rst busy", 32'(ifc.busy), 32'd1);
        rst = 1'b0;
        wait_sweep("reinit", 15);
        step();
        set_init_model();
        check_all("reinit");

        // fill_start during FILL is ignored
        ifc.fill_start = 1'b1;
        ifc.fill_char  = 7'h2E;
        step();
        ifc.fill_start = 1'b0;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                ifc.fill_start = 1'b1;
                ifc.fill_char  = 7'h21;
            end
            if (ifc.busy === 1'b1) nb++;
            step();
        end
        ifc.fill_start = 1'b0;
        check("fill2 early busy", 32'(nb), 32'd4);
        wait_sweep("fill2", 11);
        step();
        check("fill2 done once", 32'(ifc.done), 32'd0);
        set_fill_model(7'h2E);
        check_all("fill2");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end
endmodule
